// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator
//
// Purpose: 4x4 wormhole switch allocator. Each output (A..D) owns a small
// IDLE/LOCKED state machine, an owner register and a round-robin pointer.
// In IDLE an output picks one requesting input round-robin; the winner then
// holds the output until its tail flit transfers. Crossbar selects/enables
// and the per-input pop strobes are derived combinationally from the
// registered lock state and the current inputs.
//
// Ports:
//   clk         - single clock, all state updates on the rising edge
//   rst_n       - synchronous active-low reset
//   in_valid[i] - input i (0=A..3=D) presents a flit
//   in_dest     - bits [2i+1:2i] = destination output of input i's flit
//   in_tail[i]  - input i's current flit is the last of its packet
//   out_ready[j]- downstream of output j accepts a flit this cycle
//   sel_A..D    - crossbar input select per output
//   en_A..D     - crossbar output enable (flit transfers this cycle)
//   in_grant[i] - input i's flit is consumed this cycle
//   timeout     - one-cycle pulse on a forced lock release
//
// Configuration:
//   ALLOC_TIMEOUT_EN - when defined, a lock that sees TIMEOUT_CYC consecutive
//                      non-transfer cycles is forcibly released. When not
//                      defined, locks persist indefinitely and timeout is 0.
// ---------------------------------------------------------------------------
module switch_allocator #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_valid,
   input  logic [7:0] in_dest,
   input  logic [3:0] in_tail,
   input  logic [3:0] out_ready,
   output logic [1:0] sel_A,
   output logic [1:0] sel_B,
   output logic [1:0] sel_C,
   output logic [1:0] sel_D,
   output logic       en_A,
   output logic       en_B,
   output logic       en_C,
   output logic       en_D,
   output logic [3:0] in_grant,
   output logic       timeout
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e     state_q [4];
   state_e     state_d [4];
   logic [1:0] owner_q [4];
   logic [1:0] owner_d [4];
   logic [1:0] ptr_q   [4];
   logic [1:0] ptr_d   [4];

   logic [1:0] dest    [4];
   logic [3:0] owned;
   logic [3:0] en;
   logic [3:0] grant;
   logic [1:0] cand;
   logic       found;

`ifdef ALLOC_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];
   logic [3:0]    to_fire;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         dest[i] = in_dest[2*i +: 2];
      end

      // An input already held by a locked output may not be picked again.
      owned = '0;
      for (int j = 0; j < 4; j++) begin
         if (state_q[j] == LOCKED) begin
            owned[owner_q[j]] = 1'b1;
         end
      end

      en    = '0;
      grant = '0;
      cand  = '0;
      found = 1'b0;
`ifdef ALLOC_TIMEOUT_EN
      to_fire = '0;
`endif

      for (int j = 0; j < 4; j++) begin
         state_d[j] = state_q[j];
         owner_d[j] = owner_q[j];
         ptr_d[j]   = ptr_q[j];
`ifdef ALLOC_TIMEOUT_EN
         cnt_d[j]   = cnt_q[j];
`endif
         if (state_q[j] == LOCKED) begin
            // rst_n gates the enable so a reset mid-packet moves no flit.
            if (rst_n && in_valid[owner_q[j]] && out_ready[j] &&
                (dest[owner_q[j]] == 2'(j))) begin
               en[j]             = 1'b1;
               grant[owner_q[j]] = 1'b1;
`ifdef ALLOC_TIMEOUT_EN
               cnt_d[j]          = '0;
`endif
               if (in_tail[owner_q[j]]) begin
                  state_d[j] = IDLE;
                  ptr_d[j]   = owner_q[j] + 2'd1;
               end
            end
`ifdef ALLOC_TIMEOUT_EN
            else if (cnt_q[j] == CW'(TIMEOUT_CYC - 1)) begin
               state_d[j] = IDLE;
               ptr_d[j]   = owner_q[j] + 2'd1;
               cnt_d[j]   = '0;
               to_fire[j] = 1'b1;
            end else begin
               cnt_d[j] = cnt_q[j] + CW'(1);
            end
`endif
         end else begin
            // Round-robin: first candidate at or after the pointer, mod 4.
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
               cand = ptr_q[j] + 2'(k);
               if (!found && in_valid[cand] && (dest[cand] == 2'(j)) &&
                   !owned[cand]) begin
                  found      = 1'b1;
                  owner_d[j] = cand;
                  state_d[j] = LOCKED;
               end
            end
`ifdef ALLOC_TIMEOUT_EN
            cnt_d[j] = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int j = 0; j < 4; j++) begin
            state_q[j] <= IDLE;
            owner_q[j] <= 2'd0;
            ptr_q[j]   <= 2'd0;
`ifdef ALLOC_TIMEOUT_EN
            cnt_q[j]   <= '0;
`endif
         end
      end else begin
         for (int j = 0; j < 4; j++) begin
            state_q[j] <= state_d[j];
            owner_q[j] <= owner_d[j];
            ptr_q[j]   <= ptr_d[j];
`ifdef ALLOC_TIMEOUT_EN
            cnt_q[j]   <= cnt_d[j];
`endif
         end
      end
   end

   // In IDLE the select simply keeps showing the last owner.
   assign sel_A    = owner_q[0];
   assign sel_B    = owner_q[1];
   assign sel_C    = owner_q[2];
   assign sel_D    = owner_q[3];
   assign en_A     = en[0];
   assign en_B     = en[1];
   assign en_C     = en[2];
   assign en_D     = en[3];
   assign in_grant = grant;

`ifdef ALLOC_TIMEOUT_EN
   assign timeout = rst_n & (|to_fire);
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_switch_allocator
//
// Self-checking bench for switch_allocator. A behavioural model tracks, per
// output, whether it is held, by whom, and where round-robin resumes; a
// negedge compare process checks every output against it each cycle.
// Directed scenarios add hand-computed literal expectations, then a long
// randomized phase exercises contention, stalls and mid-packet resets.
// ---------------------------------------------------------------------------
module tb_switch_allocator;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_valid;
   logic [7:0] in_dest;
   logic [3:0] in_tail;
   logic [3:0] out_ready;
   logic [1:0] sel_A, sel_B, sel_C, sel_D;
   logic       en_A, en_B, en_C, en_D;
   logic [3:0] in_grant;
   logic       timeout;

   always #5 clk = ~clk;

   switch_allocator #(.TIMEOUT_CYC(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_dest   (in_dest),
      .in_tail   (in_tail),
      .out_ready (out_ready),
      .sel_A     (sel_A),
      .sel_B     (sel_B),
      .sel_C     (sel_C),
      .sel_D     (sel_D),
      .en_A      (en_A),
      .en_B      (en_B),
      .en_C      (en_C),
      .en_D      (en_D),
      .in_grant  (in_grant),
      .timeout   (timeout)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit checking = 1'b0;

   // ---------------- behavioural model ----------------
   bit         m_busy [4];
   int         m_own  [4];
   int         m_ptr  [4];
   int         m_cnt  [4];
   bit [3:0]   e_en;
   bit [3:0]   e_grant;
   logic [1:0] e_sel  [4];
   bit         e_to;

   function automatic int dest_of(int i);
      return int'((in_dest >> (2 * i)) & 8'h3);
   endfunction

   // Expected outputs from the current model state and current inputs.
   function automatic void model_eval();
      e_en    = '0;
      e_grant = '0;
      e_to    = 1'b0;
      for (int j = 0; j < 4; j++) begin
         e_sel[j] = 2'(m_own[j]);
         if (rst_n === 1'b1 && m_busy[j]) begin
            if (in_valid[m_own[j]] && out_ready[j] && dest_of(m_own[j]) == j) begin
               e_en[j]            = 1'b1;
               e_grant[m_own[j]]  = 1'b1;
            end
`ifdef ALLOC_TIMEOUT_EN
            else if (m_cnt[j] + 1 == TO) begin
               e_to = 1'b1;
            end
`endif
         end
      end
   endfunction

   function automatic void model_step();
      bit owned [4];
      bit got;
      int i;
      if (rst_n !== 1'b1) begin
         for (int j = 0; j < 4; j++) begin
            m_busy[j] = 1'b0;
            m_own[j]  = 0;
            m_ptr[j]  = 0;
            m_cnt[j]  = 0;
         end
         return;
      end
      model_eval();
      for (int k = 0; k < 4; k++) owned[k] = 1'b0;
      for (int j = 0; j < 4; j++) if (m_busy[j]) owned[m_own[j]] = 1'b1;
      for (int j = 0; j < 4; j++) begin
         if (m_busy[j]) begin
            if (e_en[j]) begin
               m_cnt[j] = 0;
               if (in_tail[m_own[j]]) begin
                  m_busy[j] = 1'b0;
                  m_ptr[j]  = (m_own[j] + 1) % 4;
               end
            end else begin
`ifdef ALLOC_TIMEOUT_EN
               m_cnt[j]++;
               if (m_cnt[j] == TO) begin
                  m_busy[j] = 1'b0;
                  m_ptr[j]  = (m_own[j] + 1) % 4;
                  m_cnt[j]  = 0;
               end
`endif
            end
         end else begin
            got = 1'b0;
            for (int k = 0; k < 4; k++) begin
               i = (m_ptr[j] + k) % 4;
               if (!got && in_valid[i] && dest_of(i) == j && !owned[i]) begin
                  got       = 1'b1;
                  m_own[j]  = i;
                  m_busy[j] = 1'b1;
               end
            end
            m_cnt[j] = 0;
         end
      end
   endfunction

   always @(posedge clk) model_step();

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         model_eval();
         chk("sel", 32'({sel_D, sel_C, sel_B, sel_A}),
             32'({e_sel[3], e_sel[2], e_sel[1], e_sel[0]}));
         chk("en", 32'({en_D, en_C, en_B, en_A}), 32'(e_en));
         chk("grant", 32'(in_grant), 32'(e_grant));
         chk("timeout", 32'(timeout), 32'(e_to));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- stimulus ----------------
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 4'h0;
      next();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'hF;
      in_dest   = 8'hB1;   // A->1, B->0, C->3, D->2
      in_tail   = 4'hF;
      out_ready = 4'hF;

      // Reset with every input requesting.
      next();
      checking = 1'b1;
      mid();
      chk("rst_en", 32'({en_D, en_C, en_B, en_A}), 32'(4'h0));
      chk("rst_grant", 32'(in_grant), 32'(4'h0));
      chk("rst_sel", 32'({sel_D, sel_C, sel_B, sel_A}), 32'(8'h00));
      chk("rst_timeout", 32'(timeout), 32'(1'b0));
      next();
      rst_n = 1'b1;
      mid();
      chk("post_rst_idle_grant", 32'(in_grant), 32'(4'h0));
      next();
      // Parallel: all four outputs transfer in the same cycle.
      mid();
      chk("par_grant", 32'(in_grant), 32'(4'hF));
      chk("par_en", 32'({en_D, en_C, en_B, en_A}), 32'(4'hF));
      chk("par_sel", 32'({sel_D, sel_C, sel_B, sel_A}), 32'(8'b10_11_00_01));
      next();
      mid();
      chk("par_release", 32'(in_grant), 32'(4'h0));
      next();
      in_valid = 4'h0;
      next();

      // Contention: A,B,C single-flit packets to output B.
      do_reset();
      in_valid = 4'h7;
      in_dest  = 8'h15;
      in_tail  = 4'hF;
      for (int c = 0; c < 6; c++) begin
         mid();
         chk("cont_en", 32'(en_B), 32'(c % 2));
         if (c % 2 == 1) begin
            chk("cont_sel", 32'(sel_B), 32'(c / 2));
            chk("cont_grant", 32'(in_grant), 32'(1 << (c / 2)));
         end
         next();
      end
      in_valid = 4'h0;
      next();

      // Packet lock: A sends 3 flits to D, B asks for D mid-packet.
      do_reset();
      in_valid = 4'b0001;
      in_dest  = 8'h0F;
      in_tail  = 4'b0000;
      mid();
      chk("lock_idle", 32'(en_D), 32'(0));
      next();
      in_valid = 4'b0011;
      for (int f = 0; f < 3; f++) begin
         in_tail = (f == 2) ? 4'b0011 : 4'b0010;
         mid();
         chk("lock_en", 32'(en_D), 32'(1));
         chk("lock_sel", 32'(sel_D), 32'(0));
         chk("lock_grant", 32'(in_grant), 32'(4'b0001));
         next();
      end
      in_valid = 4'b0010;
      mid();
      chk("lock_gap", 32'(en_D), 32'(0));
      next();
      mid();
      chk("lock_b_sel", 32'(sel_D), 32'(1));
      chk("lock_b_grant", 32'(in_grant), 32'(4'b0010));
      next();
      in_valid = 4'h0;
      next();

      // Stall: A->C held while output C is not ready.
      do_reset();
      in_valid = 4'b0001;
      in_dest  = 8'h02;
      in_tail  = 4'b0000;
      mid();
      next();
      mid();
      chk("stall_first", 32'(en_C), 32'(1));
      next();
      out_ready = 4'b1011;
      for (int c = 0; c < 5; c++) begin
         mid();
         chk("stall_en", 32'(en_C), 32'(0));
         chk("stall_grant", 32'(in_grant), 32'(0));
         next();
      end
      out_ready = 4'hF;
      in_tail   = 4'b0001;
      mid();
      chk("stall_resume", 32'(en_C), 32'(1));
      chk("stall_resume_grant", 32'(in_grant), 32'(4'b0001));
      next();
      in_valid = 4'h0;
      mid();
      chk("stall_idle", 32'(en_C), 32'(0));
      next();

      // Reset in the middle of a packet transfers nothing.
      in_valid = 4'b0001;
      in_tail  = 4'b0000;
      next();
      mid();
      chk("rmid_locked", 32'(en_C), 32'(1));
      next();
      rst_n = 1'b0;
      mid();
      chk("rmid_en", 32'(en_C), 32'(0));
      chk("rmid_grant", 32'(in_grant), 32'(0));
      next();
      rst_n    = 1'b1;
      in_valid = 4'h0;
      mid();
      chk("rmid_sel", 32'(sel_C), 32'(0));
      next();

`ifdef ALLOC_TIMEOUT_EN
      // Timeout: lock A->B idles for TO cycles, then B gets first pick.
      do_reset();
      in_valid = 4'b0001;
      in_dest  = 8'h01;
      in_tail  = 4'b0000;
      next();
      mid();
      chk("to_lock", 32'(en_B), 32'(1));
      next();
      in_valid = 4'h0;
      for (int c = 0; c < TO; c++) begin
         mid();
         chk("to_pulse", 32'(timeout), 32'(c == TO - 1));
         next();
      end
      in_valid = 4'b0011;
      in_dest  = 8'h05;
      in_tail  = 4'hF;
      mid();
      chk("to_after", 32'(timeout), 32'(0));
      chk("to_idle", 32'(en_B), 32'(0));
      next();
      mid();
      chk("to_ptr_sel", 32'(sel_B), 32'(1));
      chk("to_ptr_grant", 32'(in_grant), 32'(4'b0010));
      next();
`else
      // No timeout: lock A->B survives a long idle stretch.
      do_reset();
      in_valid = 4'b0001;
      in_dest  = 8'h01;
      in_tail  = 4'b0000;
      next();
      next();
      in_valid = 4'b0010;
      in_dest  = 8'h05;
      for (int c = 0; c < 20; c++) begin
         mid();
         chk("nto_timeout", 32'(timeout), 32'(0));
         chk("nto_en", 32'(en_B), 32'(0));
         next();
      end
      in_valid = 4'b0011;
      in_tail  = 4'hF;
      mid();
      chk("nto_resume_sel", 32'(sel_B), 32'(0));
      chk("nto_resume_grant", 32'(in_grant), 32'(4'b0001));
      next();
`endif
      in_valid = 4'h0;
      next();

      // Randomized traffic, two density regimes.
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(199) != 0);
         if ($urandom_range(3) == 0) in_dest = 8'($urandom);
         for (int i = 0; i < 4; i++) begin
            if (c < 2000) in_valid[i] = ($urandom_range(1) == 0);
            else          in_valid[i] = ($urandom_range(7) == 0);
            in_tail[i]   = ($urandom_range(2) == 0);
            out_ready[i] = ($urandom_range(3) != 0);
         end
         next();
      end

      rst_n    = 1'b1;
      in_valid = 4'h0;
      next();
      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
